// File: rtl/cpu_pkg.sv
// Shared constants and types for the writeback / register-file slice of the CPU.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;

    // True when a writeback actually lands in the architectural state.
    function automatic logic is_commit(input logic we, input reg_idx_t rd);
        return we && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General-purpose register array: one write port, two combinational read ports,
// async clear, register 0 hardwired to zero.
module regfile_2r1w #(
    parameter int  NREG = cpu_pkg::NREG,
    parameter int  XLEN = cpu_pkg::XLEN,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Entry 0 is never written, but the read mux forces zero so the rule holds
    // independently of the array contents.
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register-file commit, decode read ports and commit counter.
// Define WB_BYPASS_EN to make a same-cycle commit visible on the read ports (write-before-read).
module wb_regfile #(
    parameter int  NREG  = cpu_pkg::NREG,
    parameter int  XLEN  = cpu_pkg::XLEN,
    parameter int  CNT_W = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    wb_rrwrite,
    input  logic             wb_memtoreg,
    input  logic             wb_regwrite,
    input  logic [XLEN-1:0]  wb_alu_out,
    input  logic [XLEN-1:0]  wb_memory_read,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    output logic [XLEN-1:0]  rs_data,
    output logic [XLEN-1:0]  rt_data,
    output logic [XLEN-1:0]  wb_write_data,
    output logic [CNT_W-1:0] commit_count
);

    logic            commit;
    logic [XLEN-1:0] rs_array;
    logic [XLEN-1:0] rt_array;

    assign wb_write_data = wb_memtoreg ? wb_memory_read : wb_alu_out;
    assign commit        = wb_regwrite && (wb_rrwrite != '0);

    regfile_2r1w #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_regwrite),
        .waddr   (wb_rrwrite),
        .wdata   (wb_write_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_array),
        .rdata_b (rt_array)
    );

`ifdef WB_BYPASS_EN
    // Reset gates the bypass so reads stay zero while rst is held.
    assign rs_data = (!rst && commit && (rs_addr == wb_rrwrite)) ? wb_write_data : rs_array;
    assign rt_data = (!rst && commit && (rt_addr == wb_rrwrite)) ? wb_write_data : rt_array;
`else
    assign rs_data = rs_array;
    assign rt_data = rt_array;
`endif

    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_count <= '0;
        end else if (commit) begin
            commit_count <= commit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal cases plus randomized traffic
// compared every cycle against a behavioural register-file model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wb_rrwrite = '0;
    logic        wb_memtoreg = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [31:0] wb_alu_out = '0;
    logic [31:0] wb_memory_read = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;

    logic [31:0] rs_data, rt_data, wb_write_data, commit_count;
    logic [31:0] rs_data_s, rt_data_s, wb_write_data_s;
    logic [3:0]  commit_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count = '0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .wb_rrwrite     (wb_rrwrite),
        .wb_memtoreg    (wb_memtoreg),
        .wb_regwrite    (wb_regwrite),
        .wb_alu_out     (wb_alu_out),
        .wb_memory_read (wb_memory_read),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_write_data  (wb_write_data),
        .commit_count   (commit_count)
    );

    // Narrow-counter build, sharing every input, exercises the wrap.
    wb_regfile #(.CNT_W(4)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .wb_rrwrite     (wb_rrwrite),
        .wb_memtoreg    (wb_memtoreg),
        .wb_regwrite    (wb_regwrite),
        .wb_alu_out     (wb_alu_out),
        .wb_memory_read (wb_memory_read),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data_s),
        .rt_data        (rt_data_s),
        .wb_write_data  (wb_write_data_s),
        .commit_count   (commit_count_s)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic m2r, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [4:0] ra, input logic [4:0] rb);
        wb_regwrite    = we;
        wb_memtoreg    = m2r;
        wb_rrwrite     = rd;
        wb_alu_out     = alu;
        wb_memory_read = mem;
        rs_addr        = ra;
        rt_addr        = rb;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] selected_value();
        return wb_memtoreg ? wb_memory_read : wb_alu_out;
    endfunction

    function automatic logic [31:0] expected_read(input logic [4:0] addr);
        if (rst || addr == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_regwrite && wb_rrwrite == addr) return selected_value();
`endif
        return m_regs[addr];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end

    // Architectural state as the specification describes it: one commit per edge, x0 ignored.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_count <= '0;
        end else if (wb_regwrite && wb_rrwrite != 5'd0) begin
            m_regs[wb_rrwrite] <= selected_value();
            m_count <= m_count + 32'd1;
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_rs", rs_data, expected_read(rs_addr));
        checkOutput("cmp_rt", rt_data, expected_read(rt_addr));
        checkOutput("cmp_wbdata", wb_write_data, selected_value());
        checkOutput("cmp_count", commit_count, m_count);
        checkOutput("cmp_rs_small", rs_data_s, expected_read(rs_addr));
        checkOutput("cmp_count_small", {28'd0, commit_count_s}, {28'd0, m_count[3:0]});
    end

    initial begin
        @(negedge clk);
        checkOutput("reset_rs", rs_data, 32'h0);
        checkOutput("reset_count", commit_count, 32'h0);
        nextCycle();
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        @(negedge clk);
        checkOutput("alu_commit_rs", rs_data, 32'h1234_5678);
        checkOutput("alu_commit_count", commit_count, 32'd1);

        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd31, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd31);
        @(negedge clk);
        checkOutput("load_wbdata", wb_write_data, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd31);
        @(negedge clk);
        checkOutput("load_commit_rt", rt_data, 32'hDEAD_BEEF);
        checkOutput("load_commit_count", commit_count, 32'd2);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("x0_write_cycle_rs", rs_data, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("x0_rs", rs_data, 32'h0);
        checkOutput("x0_count", commit_count, 32'd2);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h1, 32'h0, 5'd7, 5'd7);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h2, 32'h0, 5'd7, 5'd7);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        checkOutput("same_cycle_rs", rs_data, 32'h2);
        checkOutput("same_cycle_rt", rt_data, 32'h2);
`else
        checkOutput("same_cycle_rs", rs_data, 32'h1);
        checkOutput("same_cycle_rt", rt_data, 32'h1);
`endif
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
        @(negedge clk);
        checkOutput("after_rs", rs_data, 32'h2);
        checkOutput("after_rt", rt_data, 32'h2);
        checkOutput("after_count", commit_count, 32'd4);

        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd9, 32'hAAAA_AAAA, 32'h0, 5'd9, 5'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("nowrite_rs", rs_data, 32'h0);
        checkOutput("nowrite_count", commit_count, 32'd4);

        for (int i = 0; i < 11; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 5'd10, 32'(i), 32'h0, 5'd10, 5'd0);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        @(negedge clk);
        checkOutput("small_count_all_ones", {28'd0, commit_count_s}, 32'd15);
        checkOutput("count_fifteen", commit_count, 32'd15);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd10, 32'h99, 32'h0, 5'd10, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        @(negedge clk);
        checkOutput("small_count_wrap", {28'd0, commit_count_s}, 32'd0);
        checkOutput("count_sixteen", commit_count, 32'd16);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd, ra, rb;
            rd = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            nextCycle();
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rd,
                          $urandom, $urandom, ra, rb);
        end

        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd3, 32'h5555_5555, 32'h0, 5'd3, 5'd5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_reset_rs", rs_data, 32'h0);
        checkOutput("midrun_reset_rt", rt_data, 32'h0);
        checkOutput("midrun_reset_count", commit_count, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd5);
        @(negedge clk);
        checkOutput("lost_write_rs", rs_data, 32'h0);
        checkOutput("lost_write_count", commit_count, 32'h0);

        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
